// File: rtl/reg_file_mp_pkg.sv
// Shared constants, types and slice helpers for the multi-port register file.
package reg_file_mp_pkg;

  localparam int unsigned NWP     = 2;
  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned PW_DEF  = 4;
  localparam int unsigned PCW_DEF = 12;

  typedef enum logic {
    WP_ALU  = 1'b0,
    WP_LOAD = 1'b1
  } wp_e;

  typedef logic [PW_DEF-1:0]  addr_t;
  typedef logic [DW_DEF-1:0]  data_t;
  typedef logic [PCW_DEF-1:0] pc_t;

  // Pick one write port's field out of a packed per-port bus at default widths
  function automatic addr_t wr_addr_of(input logic [NWP*PW_DEF-1:0] bus, input wp_e p);
    return (p == WP_LOAD) ? bus[2*PW_DEF-1:PW_DEF] : bus[PW_DEF-1:0];
  endfunction

  function automatic data_t wr_dat_of(input logic [NWP*DW_DEF-1:0] bus, input wp_e p);
    return (p == WP_LOAD) ? bus[2*DW_DEF-1:DW_DEF] : bus[DW_DEF-1:0];
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: write ports with PC tag, read ports, status.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned PW  = PW_DEF,
  parameter int unsigned NR  = 2,
  parameter int unsigned PCW = PCW_DEF
);

  logic                 clr;
  logic [PCW-1:0]       prog_ctr;
  logic [NWP-1:0]       wr_en;
  logic [NWP*PW-1:0]    wr_addr;
  logic [NWP*DW-1:0]    wr_dat;
  logic [NR*PW-1:0]     rd_addr;
  logic [NR*DW-1:0]     rd_dat;
  logic [(2**PW)-1:0]   valid;
  logic [NWP-1:0]       wr_drop;

  modport master (
    output clr, prog_ctr, wr_en, wr_addr, wr_dat, rd_addr,
    input  rd_dat, valid, wr_drop
  );

  modport slave (
    input  clr, prog_ctr, wr_en, wr_addr, wr_dat, rd_addr,
    output rd_dat, valid, wr_drop
  );

endinterface

// File: rtl/rf_wr_guard.sv
// Per-write-port PC guard: a held-over instruction may write only once.
module rf_wr_guard #(
  parameter int unsigned PCW = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [PCW-1:0] prog_ctr,
  output logic           accept_c,
  output logic           wr_drop
);

  logic [PCW-1:0] last_pc;
  logic           guard_vld;
  logic           blocked_c;

  assign blocked_c = guard_vld && (prog_ctr == last_pc);
  assign accept_c  = wr_en && !blocked_c && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc   <= '1;
      guard_vld <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop <= wr_en && blocked_c && !clr;
      if (clr) begin
        guard_vld <= 1'b0;
      end else if (accept_c) begin
        last_pc   <= prog_ctr;
        guard_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NR combinational reads, two PC-guarded writes, valid mask, sync clear.
// Optional write-to-read forwarding when REG_FILE_MP_BYPASS_EN is defined.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned PW  = PW_DEF,
  parameter int unsigned NR  = 2,
  parameter int unsigned PCW = PCW_DEF
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2**PW;

  logic [DW-1:0]    core [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [NWP-1:0]   accept_c;
  logic [NWP-1:0]   wr_drop_q;

  for (genvar p = 0; p < NWP; p++) begin : g_guard
    rf_wr_guard #(.PCW(PCW)) u_guard (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .wr_en    (bus.wr_en[p]),
      .prog_ctr (bus.prog_ctr),
      .accept_c (accept_c[p]),
      .wr_drop  (wr_drop_q[p])
    );
  end

  // Port order gives the load port the last word on a same-address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core    <= '{default: '0};
      valid_q <= '0;
    end else if (bus.clr) begin
      core    <= '{default: '0};
      valid_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NWP; p++) begin
        if (accept_c[p]) begin
          core[bus.wr_addr[p*PW +: PW]]    <= bus.wr_dat[p*DW +: DW];
          valid_q[bus.wr_addr[p*PW +: PW]] <= 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [PW-1:0] ra_c;
    logic [DW-1:0] rd_c;

    assign ra_c = bus.rd_addr[r*PW +: PW];

    always_comb begin
      rd_c = core[ra_c];
`ifdef REG_FILE_MP_BYPASS_EN
      for (int unsigned p = 0; p < NWP; p++) begin
        if (accept_c[p] && (bus.wr_addr[p*PW +: PW] == ra_c)) begin
          rd_c = bus.wr_dat[p*DW +: DW];
        end
      end
`endif
    end

    assign bus.rd_dat[r*DW +: DW] = rd_c;
  end

  assign bus.valid   = valid_q;
  assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed cases plus randomized traffic against an array model.
module tb_reg_file_mp;
  import reg_file_mp_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned PW    = 4;
  localparam int unsigned NR    = 2;
  localparam int unsigned PCW   = 12;
  localparam int unsigned DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DW(DW), .PW(PW), .NR(NR), .PCW(PCW)) rf_if ();

  reg_file_mp #(.DW(DW), .PW(PW), .NR(NR), .PCW(PCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if)
  );

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  // Behavioural model: plain arrays updated by the architectural write rules
  logic [DW-1:0]    mdl     [DEPTH];
  logic [DEPTH-1:0] mdl_vld;
  logic [PCW-1:0]   mdl_pc  [2];
  bit               mdl_gv  [2];
  logic [1:0]       mdl_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wp_e port_of(input int p);
    return (p == 1) ? WP_LOAD : WP_ALU;
  endfunction

  function automatic bit accepted(input int p);
    return rf_if.wr_en[p] && !rf_if.clr && !(mdl_gv[p] && (rf_if.prog_ctr == mdl_pc[p]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc [2];
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] <= '0;
      mdl_vld  <= '0;
      mdl_pc[0] <= '1;
      mdl_pc[1] <= '1;
      mdl_gv[0] <= 1'b0;
      mdl_gv[1] <= 1'b0;
      mdl_drop <= '0;
    end else if (rf_if.clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] <= '0;
      mdl_vld  <= '0;
      mdl_gv[0] <= 1'b0;
      mdl_gv[1] <= 1'b0;
      mdl_drop <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        acc[p] = accepted(p);
        mdl_drop[p] <= rf_if.wr_en[p] && !acc[p];
      end
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          mdl[wr_addr_of(rf_if.wr_addr, port_of(p))]     <= wr_dat_of(rf_if.wr_dat, port_of(p));
          mdl_vld[wr_addr_of(rf_if.wr_addr, port_of(p))] <= 1'b1;
          mdl_pc[p] <= rf_if.prog_ctr;
          mdl_gv[p] <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle compare, sampled mid low phase after inputs have settled
  always @(negedge clk) begin
    #2;
    if (chk_en && rst_n) begin
      check("valid", 32'(rf_if.valid), 32'(mdl_vld));
      check("wr_drop", 32'(rf_if.wr_drop), 32'(mdl_drop));
      for (int r = 0; r < int'(NR); r++) begin
        logic [PW-1:0] ra;
        logic [DW-1:0] exp;
        ra  = rf_if.rd_addr[r*PW +: PW];
        exp = mdl[ra];
`ifdef REG_FILE_MP_BYPASS_EN
        for (int p = 0; p < 2; p++)
          if (accepted(p) && (wr_addr_of(rf_if.wr_addr, port_of(p)) == ra))
            exp = wr_dat_of(rf_if.wr_dat, port_of(p));
`endif
        check($sformatf("rd_dat%0d", r), 32'(rf_if.rd_dat[r*DW +: DW]), 32'(exp));
      end
    end
  end

  task automatic idle();
    rf_if.wr_en = 2'b00;
    rf_if.clr   = 1'b0;
  endtask

  task automatic drive_wr(input logic [PCW-1:0] pc, input logic [1:0] en,
                          input logic [3:0] a0, input logic [7:0] d0,
                          input logic [3:0] a1, input logic [7:0] d1);
    rf_if.prog_ctr = pc;
    rf_if.wr_en    = en;
    rf_if.wr_addr  = {a1, a0};
    rf_if.wr_dat   = {d1, d0};
  endtask

  function automatic logic [31:0] rd0();
    return 32'(rf_if.rd_dat[DW-1:0]);
  endfunction

  initial begin
    rf_if.clr      = 1'b0;
    rf_if.prog_ctr = '0;
    rf_if.wr_en    = '0;
    rf_if.wr_addr  = '0;
    rf_if.wr_dat   = '0;
    rf_if.rd_addr  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_valid", 32'(rf_if.valid), 32'h0);
    check("rst_wr_drop", 32'(rf_if.wr_drop), 32'h0);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rf_if.rd_addr = {4'(15 - a), 4'(a)};
      #1;
      check($sformatf("rst_reg%0d", a), rd0(), 32'h0);
      check($sformatf("rst_reg%0d_p1", 15 - a), 32'(rf_if.rd_dat[2*DW-1:DW]), 32'h0);
    end

    // First accepted ALU write
    @(negedge clk);
    drive_wr(12'h005, 2'b01, 4'd3, 8'hA5, 4'd0, 8'h00);
    @(negedge clk);
    idle();
    rf_if.rd_addr = {4'd0, 4'd3};
    #1;
    check("wr_reg3", rd0(), 32'hA5);
    check("wr_valid", 32'(rf_if.valid), 32'h0008);
    check("wr_drop0", 32'(rf_if.wr_drop), 32'h0);

    // Same PC held: every repeat suppressed
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_wr(12'h005, 2'b01, 4'd3, 8'h11, 4'd0, 8'h00);
      #1;
      check("hold_reg3", rd0(), 32'hA5);
      if (i > 0) check("hold_drop", 32'(rf_if.wr_drop), 32'h1);
    end
    @(negedge clk);
    idle();
    #1;
    check("hold_drop_last", 32'(rf_if.wr_drop), 32'h1);
    check("hold_reg3_last", rd0(), 32'hA5);
    @(negedge clk);
    #1;
    check("drop_one_wide", 32'(rf_if.wr_drop), 32'h0);

    // Both ports to one address: load wins
    @(negedge clk);
    drive_wr(12'h006, 2'b11, 4'd7, 8'h22, 4'd7, 8'h33);
    @(negedge clk);
    idle();
    rf_if.rd_addr = {4'd3, 4'd7};
    #1;
    check("collide_reg7", rd0(), 32'h33);
    check("collide_drop", 32'(rf_if.wr_drop), 32'h0);

    // Clear overrides writes and releases the guards
    @(negedge clk);
    drive_wr(12'h009, 2'b11, 4'd1, 8'hEE, 4'd2, 8'hDD);
    rf_if.clr = 1'b1;
    @(negedge clk);
    idle();
    #1;
    check("clr_valid", 32'(rf_if.valid), 32'h0);
    check("clr_reg7", rd0(), 32'h0);
    check("clr_drop", 32'(rf_if.wr_drop), 32'h0);
    drive_wr(12'h009, 2'b01, 4'd9, 8'h4E, 4'd0, 8'h00);
    @(negedge clk);
    drive_wr(12'h009, 2'b01, 4'd9, 8'h99, 4'd0, 8'h00);
    rf_if.rd_addr = {4'd0, 4'd9};
    #1;
    check("post_clr_reg9", rd0(), 32'h4E);
    check("post_clr_valid", 32'(rf_if.valid), 32'h0200);
    @(negedge clk);
    idle();
    #1;
    check("post_clr_guard", rd0(), 32'h4E);
    check("post_clr_drop", 32'(rf_if.wr_drop), 32'h1);

    // Same-cycle read of the entry being written
    @(negedge clk);
    drive_wr(12'h007, 2'b01, 4'd2, 8'h5C, 4'd0, 8'h00);
    rf_if.rd_addr = {4'd0, 4'd2};
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    check("same_cycle_reg2", rd0(), 32'h5C);
`else
    check("same_cycle_reg2", rd0(), 32'h00);
`endif
    @(negedge clk);
    idle();
    #1;
    check("next_cycle_reg2", rd0(), 32'h5C);

    // Async reset during a write: the write is lost and the guard forgotten
    @(negedge clk);
    drive_wr(12'h008, 2'b01, 4'd5, 8'h77, 4'd0, 8'h00);
    rf_if.rd_addr = {4'd0, 4'd5};
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    check("rst_mid_reg5", rd0(), 32'h0);
    check("rst_mid_valid", 32'(rf_if.valid), 32'h0);
    drive_wr(12'h008, 2'b01, 4'd5, 8'h66, 4'd0, 8'h00);
    @(negedge clk);
    idle();
    #1;
    check("rst_mid_rewrite", rd0(), 32'h66);
    check("rst_mid_drop", 32'(rf_if.wr_drop), 32'h0);

    // Randomized traffic; small PC range exercises the guards heavily
    repeat (600) begin
      @(negedge clk);
      rf_if.clr      = ($urandom_range(0, 29) == 0);
      rf_if.prog_ctr = 12'($urandom_range(0, 3));
      rf_if.wr_en    = 2'($urandom);
      rf_if.wr_addr  = 8'($urandom);
      rf_if.wr_dat   = 16'($urandom);
      rf_if.rd_addr  = 8'($urandom);
    end

    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
